// File: rtl/weight_bank.sv
// weight_bank: synaptic weight store with LFSR random fill and saturating update port
module weight_bank #(
  parameter int NUM_SYNAPSES = 100,
  parameter int WIDTH_P = 8,
  parameter int SEED = 42,
  parameter int INIT_ON_RESET = 1,
  localparam int ADDR_W = $clog2(NUM_SYNAPSES)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            init_i,
  output logic                            busy_o,
  input  logic                            wr_valid_i,
  output logic                            wr_ready_o,
  input  logic [ADDR_W-1:0]               wr_addr_i,
  input  logic [1:0]                      wr_mode_i,
  input  logic [WIDTH_P-1:0]              wr_data_i,
  output logic                            addr_err_o,
  output logic [NUM_SYNAPSES*WIDTH_P-1:0] weights_o
);
  typedef enum logic {IDLE, INIT} state_t;
  localparam logic [7:0] SEED_V = (SEED[7:0] == 8'h00) ? 8'h01 : SEED[7:0];
  localparam state_t RST_STATE = (INIT_ON_RESET != 0) ? INIT : IDLE;
  state_t state, next_state;
  logic [7:0] lfsr, lfsr_next;
  logic [ADDR_W-1:0] cnt, idx;
  logic last, hs, in_range;
  logic [WIDTH_P-1:0] cur, upd;
  logic [WIDTH_P:0] sum;
  assign busy_o = state == INIT;
  assign wr_ready_o = state == IDLE;
  assign hs = wr_valid_i & wr_ready_o;
  assign in_range = 32'(wr_addr_i) < NUM_SYNAPSES;
  assign last = 32'(cnt) == NUM_SYNAPSES - 1;
  assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  // next state and the per-mode update value; increment saturates via the carry bit
  always_comb begin
    next_state = (state == IDLE) ? (init_i ? INIT : IDLE) : (last ? IDLE : INIT);
    idx = in_range ? wr_addr_i : '0;
    cur = weights_o[idx*WIDTH_P +: WIDTH_P];
    sum = {1'b0, cur} + {1'b0, wr_data_i};
    upd = (wr_mode_i == 2'd0) ? wr_data_i :
          (wr_mode_i == 2'd1) ? (sum[WIDTH_P] ? '1 : sum[WIDTH_P-1:0]) :
          (wr_mode_i == 2'd2) ? ((cur > wr_data_i) ? cur - wr_data_i : '0) : '0;
  end
  // state, LFSR fill and update application
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= RST_STATE;
      lfsr <= SEED_V;
      cnt <= '0;
      addr_err_o <= 1'b0;
      weights_o <= '0;
    end else begin
      state <= next_state;
      addr_err_o <= hs & ~in_range;
      if (state == INIT) begin
        weights_o[cnt*WIDTH_P +: WIDTH_P] <= lfsr[WIDTH_P-1:0];
        lfsr <= lfsr_next;
        cnt <= last ? '0 : cnt + 1'b1;
      end else begin
        if (init_i) cnt <= '0;
        if (hs && in_range) weights_o[idx*WIDTH_P +: WIDTH_P] <= upd;
      end
    end
  end
endmodule

// File: tb/tb_weight_bank.sv
// tb_weight_bank: randomized and directed checks of weight_bank against a behavioural model
module tb_weight_bank;
  localparam int N = 6;
  localparam int W = 8;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_i = 1'b1, init_i = 1'b0, wr_valid_i = 1'b0;
  logic [2:0] wr_addr_i = '0;
  logic [1:0] wr_mode_i = '0;
  logic [7:0] wr_data_i = '0;
  logic busy, ready, err;
  logic [N*W-1:0] weights;
  logic init2 = 1'b0, v2 = 1'b0;
  logic [1:0] a2 = '0, m2 = '0;
  logic [3:0] d2 = '0;
  logic busy2, ready2, err2;
  logic [11:0] weights2;
  int checks = 0, errors = 0;

  weight_bank #(.NUM_SYNAPSES(N), .WIDTH_P(W), .SEED(42), .INIT_ON_RESET(1)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .init_i(init_i), .busy_o(busy), .wr_valid_i(wr_valid_i),
    .wr_ready_o(ready), .wr_addr_i(wr_addr_i), .wr_mode_i(wr_mode_i), .wr_data_i(wr_data_i),
    .addr_err_o(err), .weights_o(weights));

  weight_bank #(.NUM_SYNAPSES(3), .WIDTH_P(4), .SEED(0), .INIT_ON_RESET(0)) u_dut2 (
    .clk_i(clk), .rst_i(rst_i), .init_i(init2), .busy_o(busy2), .wr_valid_i(v2),
    .wr_ready_o(ready2), .wr_addr_i(a2), .wr_mode_i(m2), .wr_data_i(d2),
    .addr_err_o(err2), .weights_o(weights2));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] step(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  int m_w[N];
  logic [7:0] m_lfsr;
  int fill_left, fill_idx, ma, md;
  bit m_err;
  logic [N*W-1:0] exp_bus;

  always @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      foreach (m_w[i]) m_w[i] = 0;
      m_lfsr = 8'd42;
      fill_left = N;
      fill_idx = 0;
      m_err = 0;
    end else begin
      m_err = 0;
      if (fill_left > 0) begin
        m_w[fill_idx] = int'(m_lfsr);
        m_lfsr = step(m_lfsr);
        fill_idx++;
        fill_left--;
      end else begin
        if (wr_valid_i) begin
          ma = int'(wr_addr_i);
          md = int'(wr_data_i);
          if (ma >= N) m_err = 1;
          else case (wr_mode_i)
            2'd0: m_w[ma] = md;
            2'd1: m_w[ma] = (m_w[ma] + md > 255) ? 255 : m_w[ma] + md;
            2'd2: m_w[ma] = (m_w[ma] - md < 0) ? 0 : m_w[ma] - md;
            default: m_w[ma] = 0;
          endcase
        end
        if (init_i) begin
          fill_left = N;
          fill_idx = 0;
        end
      end
    end
  end

  always @(posedge clk) begin
    #2;
    for (int i = 0; i < N; i++) exp_bus[i*W +: W] = 8'(m_w[i]);
    chk("weights", 64'(weights), 64'(exp_bus));
    chk("busy", 64'(busy), 64'(fill_left > 0));
    chk("ready", 64'(ready), 64'(fill_left == 0));
    chk("addr_err", 64'(err), 64'(m_err));
  end

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic upd(input logic [2:0] a, input logic [1:0] m, input logic [7:0] d);
    wr_valid_i = 1'b1;
    wr_addr_i = a;
    wr_mode_i = m;
    wr_data_i = d;
    @(negedge clk);
    wr_valid_i = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    chk("d2_busy_reset", 64'(busy2), 64'd0);
    chk("d2_ready_reset", 64'(ready2), 64'd1);
    chk("d2_weights_reset", 64'(weights2), 64'd0);
    wait_idle();
    chk("fill_w0", 64'(weights[7:0]), 64'h2A);
    chk("fill_w1", 64'(weights[15:8]), 64'h54);
    chk("fill_w2", 64'(weights[23:16]), 64'hA9);
    chk("fill_w3", 64'(weights[31:24]), 64'h53);
    chk("d2_weights_idle", 64'(weights2), 64'd0);
    init_i = 1'b1;
    @(negedge clk);
    init_i = 1'b0;
    wait_idle();
    chk("reinit_w0", 64'(weights[7:0]), 64'h9D);
    chk("reinit_w1", 64'(weights[15:8]), 64'h3B);
    upd(3'd1, 2'd0, 8'hF0);
    chk("write_f0", 64'(weights[15:8]), 64'hF0);
    upd(3'd1, 2'd1, 8'h20);
    chk("inc_sat", 64'(weights[15:8]), 64'hFF);
    upd(3'd1, 2'd0, 8'h05);
    upd(3'd1, 2'd2, 8'h09);
    chk("dec_sat", 64'(weights[15:8]), 64'h00);
    upd(3'd1, 2'd0, 8'h10);
    upd(3'd1, 2'd1, 8'h01);
    chk("inc_plain", 64'(weights[15:8]), 64'h11);
    upd(3'd2, 2'd3, 8'hAB);
    chk("clear", 64'(weights[23:16]), 64'h00);
    upd(3'd7, 2'd0, 8'h55);
    chk("err_pulse", 64'(err), 64'd1);
    @(negedge clk);
    chk("err_drop", 64'(err), 64'd0);
    wr_valid_i = 1'b1;
    wr_addr_i = 3'd0;
    wr_mode_i = 2'd0;
    wr_data_i = 8'h77;
    init_i = 1'b1;
    @(negedge clk);
    wr_valid_i = 1'b0;
    init_i = 1'b0;
    chk("init_and_write", 64'(weights[7:0]), 64'h77);
    chk("init_busy", 64'(busy), 64'd1);
    wait_idle();
    init2 = 1'b1;
    @(negedge clk);
    init2 = 1'b0;
    for (int i = 0; i < 10 && busy2; i++) @(negedge clk);
    chk("d2_fill", 64'(weights2), 64'h421);
    v2 = 1'b1; a2 = 2'd0; m2 = 2'd1; d2 = 4'hF;
    @(negedge clk);
    chk("d2_inc_sat", 64'(weights2), 64'h42F);
    a2 = 2'd1; m2 = 2'd2; d2 = 4'h3;
    @(negedge clk);
    chk("d2_dec_sat", 64'(weights2), 64'h40F);
    a2 = 2'd3; m2 = 2'd0; d2 = 4'h9;
    @(negedge clk);
    v2 = 1'b0;
    chk("d2_err", 64'(err2), 64'd1);
    chk("d2_err_nochange", 64'(weights2), 64'h40F);
    for (int i = 0; i < 600; i++) begin
      wr_valid_i = 1'($urandom_range(0, 1));
      wr_addr_i = 3'($urandom_range(0, 7));
      wr_mode_i = 2'($urandom_range(0, 3));
      wr_data_i = 8'($urandom_range(0, 255));
      init_i = ($urandom_range(0, 39) == 0);
      @(negedge clk);
    end
    wr_valid_i = 1'b0;
    init_i = 1'b0;
    wait_idle();
    init_i = 1'b1;
    @(negedge clk);
    init_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    #1;
    chk("rst_mid_init", 64'(weights), 64'd0);
    @(negedge clk);
    rst_i = 1'b0;
    wait_idle();
    chk("refill_w0", 64'(weights[7:0]), 64'h2A);
    chk("refill_w1", 64'(weights[15:8]), 64'h54);
    chk("refill_w3", 64'(weights[31:24]), 64'h53);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/weight_bank.md
# weight_bank

- Parametrised synaptic weight store for the spiking-neuron datapath, replacing the fill-every-cycle random weight register.
- Holds NUM_SYNAPSES weights of WIDTH_P bits each and exposes them as one flat bus to the neuron array.
- Weights can be randomised from an internal 8-bit LFSR, either after reset or on command.
- Individual weights can be written, incremented, decremented (saturating) or cleared through a valid/ready update port, for learning rules.

## Interface
Parameters:
- NUM_SYNAPSES, 100: number of weights; range 2..1024.
- WIDTH_P, 8: bits per weight; range 1..8.
- SEED, 42: LFSR reset value, low 8 bits used; if those bits are 0, use 8'h01.
- INIT_ON_RESET, 1: 1 = randomise automatically after reset; 0 = weights stay 0 until init_i.
- ADDR_W, $clog2(NUM_SYNAPSES): address width; derived, not overridden.

Ports:
- clk_i  in  1  clock; everything is on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- init_i  in  1  one-cycle request to re-randomise all weights.
- busy_o  out  1  high while in INIT.
- wr_valid_i  in  1  update request.
- wr_ready_o  out  1  update accepted when it is high together with wr_valid_i.
- wr_addr_i  in  ADDR_W  target synapse.
- wr_mode_i  in  2  operation: 00 write, 01 increment, 10 decrement, 11 clear.
- wr_data_i  in  WIDTH_P  write value or step size.
- addr_err_o  out  1  one-cycle pulse when an accepted update has wr_addr_i >= NUM_SYNAPSES.
- weights_o  out  NUM_SYNAPSES*WIDTH_P  flat weight bus; weight k is bits [k*WIDTH_P +: WIDTH_P].

## Operation
Reset (rst_i high), applied asynchronously:
- every weight = 0;
- lfsr = SEED (or 8'h01 as above);
- addr_err_o = 0;
- init counter = 0;
- state = INIT if INIT_ON_RESET, else IDLE; busy_o follows the state.

LFSR:
- 8-bit Fibonacci form; next = {q[6:0], q[7]^q[5]^q[4]^q[3]}.
- Advances only on INIT cycles.
- Never reset by init_i, so each re-init produces fresh values.

State machine:
- IDLE:
  - wr_ready_o = 1, busy_o = 0.
  - init_i = 1 → INIT, with the counter cleared.
  - Any handshake in IDLE is applied, including one in the same cycle as init_i.
- INIT:
  - wr_ready_o = 0, busy_o = 1; init_i is ignored.
  - Each cycle: weight[cnt] <= lfsr[WIDTH_P-1:0], lfsr advances, cnt increments.
  - After the cycle with cnt = NUM_SYNAPSES-1, go to IDLE with cnt = 0.

Update arithmetic, all unsigned, for w = weight[wr_addr_i]:
- write: w <= wr_data_i.
- increment: w <= min(w + wr_data_i, 2^WIDTH_P - 1), computed WIDTH_P+1 bits wide with no wrap.
- decrement: w <= (w > wr_data_i) ? w - wr_data_i : 0.
- clear: w <= 0; wr_data_i is ignored.
- Out-of-range address: handshake still completes, no weight changes, addr_err_o pulses on the next cycle.

## Timing
- Updates: an accepted update is visible on weights_o on the cycle after the handshake edge. Throughput is one update per cycle in IDLE.
- INIT: busy_o is high for exactly NUM_SYNAPSES cycles. Weight k is visible k+1 cycles after INIT is entered.
- init_i pulsed in IDLE at edge t: busy_o rises after t. The first INIT write happens at edge t+1.
- After reset release with INIT_ON_RESET=1: INIT starts at the first clock edge.
- Reset mid-INIT: all weights return to 0 and the LFSR returns to SEED immediately. If INIT_ON_RESET=1, INIT restarts from address 0 after release.
- weights_o and addr_err_o are registered outputs. wr_ready_o and busy_o are decoded from the state register only.

## Test plan
- Reset/init: SEED=42, NUM_SYNAPSES=4, WIDTH_P=8, INIT_ON_RESET=1; release reset → busy_o high for 4 cycles, then weights = {0x2A, 0x54, 0xA9, 0x53} (index 0..3), wr_ready_o=1.
- Re-init: pulse init_i after the first fill → weights 0..3 take the next four LFSR states, starting after 0x53, not 0x2A again.
- Saturation: write 0xF0 to addr 1, then increment by 0x20 → 0xFF. Write 0x05, then decrement by 0x09 → 0x00. Increment 0x10 by 0x01 → 0x11.
- Mode and address checks: clear addr 2 → 0. Update at addr 4 (with N=4) → no weight changes, addr_err_o pulses once. Back-to-back updates on consecutive cycles are all applied.
- Handshake/INIT interaction: wr_valid_i held during INIT → wr_ready_o=0, no change until IDLE. wr_valid_i together with init_i in IDLE → update applied, then overwritten by INIT if its address is in range.
- Reset mid-INIT: assert rst_i after 2 INIT cycles → all weights 0 immediately. After release, the fill restarts and reproduces the 0x2A, 0x54, ... sequence. With INIT_ON_RESET=0, weights stay 0 and busy_o stays 0.
